// File: rtl/nbyn_noc_pkg.sv
// Shared nbyn NoC flit geometry: header field offsets and flit pack/unpack helpers.
// Helpers work on a wide bus so any (x_size, y_size, data_width) instance can reuse them.
package nbyn_noc_pkg;

  localparam int FLIT_MAX_W = 1024;
  localparam int X_LSB      = 0;

  typedef logic [FLIT_MAX_W-1:0] flit_bus_t;

  function automatic int y_lsb(input int xs);
    return xs;
  endfunction

  function automatic int pay_lsb(input int xs, input int ys);
    return xs + ys;
  endfunction

  // Fields are masked to their widths so oversized inputs cannot bleed into neighbours.
  function automatic flit_bus_t flit_pack(input flit_bus_t pay, input flit_bus_t dx,
                                          input flit_bus_t dy, input int xs, input int ys);
    flit_bus_t xm;
    flit_bus_t ym;
    xm = (flit_bus_t'(1) << xs) - flit_bus_t'(1);
    ym = (flit_bus_t'(1) << ys) - flit_bus_t'(1);
    return (pay << pay_lsb(xs, ys)) | ((dy & ym) << y_lsb(xs)) | ((dx & xm) << X_LSB);
  endfunction

  function automatic flit_bus_t flit_payload(input flit_bus_t flit, input int xs, input int ys);
    return flit >> pay_lsb(xs, ys);
  endfunction

endpackage

// File: rtl/nbyn_pe_ni_if.sv
// Core/switch-facing signal bundle of the nbyn PE network interface.
// slave = the NI itself; master = the core and switch side driving it.
interface nbyn_pe_ni_if
  import nbyn_noc_pkg::*;
#(
  parameter int data_width = 256,
  parameter int x_size     = 1,
  parameter int y_size     = 1
);
  localparam int total_width = pay_lsb(x_size, y_size) + data_width;

  logic                   s_valid;
  logic                   s_ready;
  logic [data_width-1:0]  s_data;
  logic [x_size-1:0]      s_dest_x;
  logic [y_size-1:0]      s_dest_y;
  logic                   o_valid_sw;
  logic [total_width-1:0] o_data_sw;
  logic                   i_ready_sw;
  logic                   i_valid_sw;
  logic [total_width-1:0] i_data_sw;
  logic                   m_valid;
  logic                   m_ready;
  logic [data_width-1:0]  m_data;
  logic                   rx_overflow;
  logic                   rx_misroute;
  logic [15:0]            rx_drop_cnt;

  modport slave (
    input  s_valid, s_data, s_dest_x, s_dest_y, i_ready_sw, i_valid_sw, i_data_sw, m_ready,
    output s_ready, o_valid_sw, o_data_sw, m_valid, m_data, rx_overflow, rx_misroute, rx_drop_cnt
  );

  modport master (
    output s_valid, s_data, s_dest_x, s_dest_y, i_ready_sw, i_valid_sw, i_data_sw, m_ready,
    input  s_ready, o_valid_sw, o_data_sw, m_valid, m_data, rx_overflow, rx_misroute, rx_drop_cnt
  );
endinterface

// File: rtl/nbyn_sync_fifo.sv
// First-word-fall-through synchronous FIFO; DEPTH must be a power of two, at least 2.
// Caller guarantees no push when full unless a pop happens in the same cycle.
module nbyn_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is data only and is never reset; empty pointers mask stale contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/nbyn_pe_ni.sv
// PE-side network interface for the nbyn deflection switch: header insert + TX FIFO, RX FIFO + header strip.
// Build option NBYN_NI_DROP_CNT_EN enables the saturating rx_drop_cnt counter (tied to 0 otherwise).
module nbyn_pe_ni
  import nbyn_noc_pkg::*;
#(
  parameter int x_coord     = 0,
  parameter int y_coord     = 0,
  parameter int data_width  = 256,
  parameter int x_size      = 1,
  parameter int y_size      = 1,
  parameter int total_width = x_size + y_size + data_width,
  parameter int TX_DEPTH    = 4,
  parameter int RX_DEPTH    = 8
) (
  input logic          clk,
  input logic          rstn,
  nbyn_pe_ni_if.slave  ni
);
  localparam int HDR_W = pay_lsb(x_size, y_size);
  localparam logic [HDR_W-1:0] OWN_HDR =
    HDR_W'(flit_pack('0, flit_bus_t'(x_coord), flit_bus_t'(y_coord), x_size, y_size));

  logic                   ready_q;
  logic                   tx_push, tx_pop, tx_full, tx_empty;
  logic [total_width-1:0] tx_din, tx_dout;
  logic                   rx_push, rx_pop, rx_full, rx_empty, rx_drop;
  logic [total_width-1:0] rx_dout;
  logic                   overflow_q, misroute_q;

  // Holds s_ready low through reset and opens it the first cycle after release.
  always_ff @(posedge clk) begin
    if (!rstn) ready_q <= 1'b0;
    else       ready_q <= 1'b1;
  end

  assign ni.s_ready = ready_q & ~tx_full;
  assign tx_push    = ni.s_valid & ni.s_ready;
  assign tx_din     = total_width'(flit_pack(flit_bus_t'(ni.s_data), flit_bus_t'(ni.s_dest_x),
                                             flit_bus_t'(ni.s_dest_y), x_size, y_size));
  // Switch-bound valid/data come purely from FIFO state, breaking any loop through o_ready_pe.
  assign ni.o_valid_sw = ~tx_empty;
  assign ni.o_data_sw  = tx_dout;
  assign tx_pop        = ni.o_valid_sw & ni.i_ready_sw;

  nbyn_sync_fifo #(.WIDTH(total_width), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rstn(rstn), .push(tx_push), .pop(tx_pop), .din(tx_din),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );

  // Ejected flits cannot be stalled: accept when a slot is or becomes free, else drop.
  assign rx_pop  = ni.m_valid & ni.m_ready;
  assign rx_push = ni.i_valid_sw & (~rx_full | rx_pop);
  assign rx_drop = ni.i_valid_sw & ~rx_push;

  nbyn_sync_fifo #(.WIDTH(total_width), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rstn(rstn), .push(rx_push), .pop(rx_pop), .din(ni.i_data_sw),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );

  assign ni.m_valid = ~rx_empty;
  assign ni.m_data  = data_width'(flit_payload(flit_bus_t'(rx_dout), x_size, y_size));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      overflow_q <= 1'b0;
      misroute_q <= 1'b0;
    end else begin
      if (rx_drop) overflow_q <= 1'b1;
      if (rx_push && (ni.i_data_sw[HDR_W-1:0] != OWN_HDR)) misroute_q <= 1'b1;
    end
  end

  assign ni.rx_overflow = overflow_q;
  assign ni.rx_misroute = misroute_q;

`ifdef NBYN_NI_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn)                            drop_cnt_q <= '0;
    else if (rx_drop && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 16'd1;
  end

  assign ni.rx_drop_cnt = drop_cnt_q;
`else
  assign ni.rx_drop_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_nbyn_pe_ni.sv
// Bench for nbyn_pe_ni (8-bit payload, 1-bit coordinates, own position x=0,y=1).
// Queue-based reference model plus directed scenarios and a randomized phase.
module tb_nbyn_pe_ni;
  localparam logic [1:0] OWN_HDR = 2'b10;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_bad;
  bit   chk_en;

  nbyn_pe_ni_if #(.data_width(8), .x_size(1), .y_size(1)) ni ();

  nbyn_pe_ni #(
    .x_coord(0), .y_coord(1), .data_width(8), .x_size(1), .y_size(1),
    .TX_DEPTH(4), .RX_DEPTH(8)
  ) dut (
    .clk(clk), .rstn(rstn), .ni(ni)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: flits as plain queues, updated on each rising edge from the driven inputs.
  logic [9:0] txq[$];
  logic [7:0] rxq[$];
  bit         ready_m;
  bit         ovf_m;
  bit         mis_m;
  int         drop_m;

  initial begin
    ready_m = 0; ovf_m = 0; mis_m = 0; drop_m = 0;
    forever begin
      @(posedge clk);
      if (!rstn) begin
        txq.delete(); rxq.delete();
        ready_m = 0; ovf_m = 0; mis_m = 0; drop_m = 0;
      end else begin
        bit tx_pop, tx_push, rx_pop, rx_push;
        tx_pop  = (txq.size() > 0) && ni.i_ready_sw;
        tx_push = ready_m && ni.s_valid && (txq.size() < 4);
        rx_pop  = (rxq.size() > 0) && ni.m_ready;
        rx_push = ni.i_valid_sw && ((rxq.size() < 8) || rx_pop);
        if (tx_pop)  void'(txq.pop_front());
        if (tx_push) txq.push_back({ni.s_data, ni.s_dest_y, ni.s_dest_x});
        if (rx_pop)  void'(rxq.pop_front());
        if (rx_push) begin
          rxq.push_back(ni.i_data_sw[9:2]);
          if (ni.i_data_sw[1:0] != OWN_HDR) mis_m = 1;
        end else if (ni.i_valid_sw) begin
          ovf_m = 1;
`ifdef NBYN_NI_DROP_CNT_EN
          if (drop_m < 65535) drop_m++;
`endif
        end
        ready_m = 1;
      end
    end
  end

  // Per-cycle comparison of every output against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("s_ready", 32'(ni.s_ready), 32'(ready_m && (txq.size() < 4)));
        check("o_valid_sw", 32'(ni.o_valid_sw), 32'(txq.size() > 0));
        if (txq.size() > 0) check("o_data_sw", 32'(ni.o_data_sw), 32'(txq[0]));
        check("m_valid", 32'(ni.m_valid), 32'(rxq.size() > 0));
        if (rxq.size() > 0) check("m_data", 32'(ni.m_data), 32'(rxq[0]));
        check("rx_overflow", 32'(ni.rx_overflow), 32'(ovf_m));
        check("rx_misroute", 32'(ni.rx_misroute), 32'(mis_m));
        check("rx_drop_cnt", 32'(ni.rx_drop_cnt), 32'(drop_m));
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  logic [7:0] tx_pat [5];
  int         vcnt;
  logic [15:0] exp_drop;

  initial begin
    n_cmp = 0; n_bad = 0; chk_en = 0;
    rstn = 1'b0;
    ni.s_valid = 0; ni.s_data = '0; ni.s_dest_x = '0; ni.s_dest_y = '0;
    ni.i_ready_sw = 0; ni.i_valid_sw = 0; ni.i_data_sw = '0; ni.m_ready = 0;
    step(); step();
    chk_en = 1;
    check("reset s_ready", 32'(ni.s_ready), 32'h0);
    check("reset o_valid_sw", 32'(ni.o_valid_sw), 32'h0);
    check("reset m_valid", 32'(ni.m_valid), 32'h0);
    rstn = 1'b1;
    step();
    check("s_ready after release", 32'(ni.s_ready), 32'h1);

    // TX basic: payload A5 to (1,0)
    ni.s_valid = 1; ni.s_data = 8'hA5; ni.s_dest_x = 1'b1; ni.s_dest_y = 1'b0; ni.i_ready_sw = 1;
    step();
    ni.s_valid = 0;
    check("tx basic valid", 32'(ni.o_valid_sw), 32'h1);
    check("tx basic flit", 32'(ni.o_data_sw), 32'h295);
    step();
    check("tx basic popped", 32'(ni.o_valid_sw), 32'h0);

    // TX backpressure: five offers into a stalled 4-entry FIFO
    tx_pat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    ni.i_ready_sw = 0; ni.s_dest_x = 1'b1; ni.s_dest_y = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ni.s_valid = 1; ni.s_data = tx_pat[i];
      step();
    end
    ni.s_valid = 0;
    check("tx full s_ready", 32'(ni.s_ready), 32'h0);
    check("tx stall head", 32'(ni.o_data_sw), 32'({8'h11, 2'b11}));
    step(); step(); step();
    check("tx stall head held", 32'(ni.o_data_sw), 32'({8'h11, 2'b11}));
    ni.i_ready_sw = 1;
    for (int i = 0; i < 4; i++) begin
      check("tx egress valid", 32'(ni.o_valid_sw), 32'h1);
      check("tx egress order", 32'(ni.o_data_sw), 32'({tx_pat[i], 2'b11}));
      step();
    end
    check("tx drained", 32'(ni.o_valid_sw), 32'h0);

    // RX basic: 10'h25A carries payload 96 addressed to (0,1)
    ni.i_valid_sw = 1; ni.i_data_sw = 10'h25A; ni.m_ready = 1;
    step();
    ni.i_valid_sw = 0;
    check("rx basic valid", 32'(ni.m_valid), 32'h1);
    check("rx basic payload", 32'(ni.m_data), 32'h96);
    check("rx basic misroute", 32'(ni.rx_misroute), 32'h0);
    step();
    check("rx basic consumed", 32'(ni.m_valid), 32'h0);

    // RX overflow: nine flits with the core not accepting
    ni.m_ready = 0;
    for (int i = 0; i < 9; i++) begin
      ni.i_valid_sw = 1; ni.i_data_sw = {8'h10 + 8'(i), OWN_HDR};
      step();
    end
    ni.i_valid_sw = 0;
    check("rx overflow flag", 32'(ni.rx_overflow), 32'h1);
`ifdef NBYN_NI_DROP_CNT_EN
    exp_drop = 16'd1;
`else
    exp_drop = 16'd0;
`endif
    check("rx drop count", 32'(ni.rx_drop_cnt), 32'(exp_drop));
    check("rx full head", 32'(ni.m_data), 32'h10);

    // RX full with a simultaneous pop: no drop, still 8 entries
    ni.i_valid_sw = 1; ni.i_data_sw = {8'hC3, OWN_HDR}; ni.m_ready = 1;
    step();
    ni.i_valid_sw = 0; ni.m_ready = 0;
    check("rx full+pop no drop", 32'(ni.rx_drop_cnt), 32'(exp_drop));
    check("rx full+pop new head", 32'(ni.m_data), 32'h11);
    ni.m_ready = 1;
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (ni.m_valid) vcnt++;
      step();
    end
    check("rx occupancy after full+pop", 32'(vcnt), 32'd8);

    // Misroute then reset clears everything, including a parked TX flit
    ni.i_ready_sw = 0; ni.s_valid = 1; ni.s_data = 8'h77;
    ni.i_valid_sw = 1; ni.i_data_sw = {8'h5A, 2'b11};
    step();
    ni.i_valid_sw = 0; ni.s_valid = 0;
    check("misroute flag", 32'(ni.rx_misroute), 32'h1);
    check("misroute still delivered", 32'(ni.m_data), 32'h5A);
    rstn = 1'b0;
    step();
    check("rst o_valid_sw", 32'(ni.o_valid_sw), 32'h0);
    check("rst m_valid", 32'(ni.m_valid), 32'h0);
    check("rst overflow", 32'(ni.rx_overflow), 32'h0);
    check("rst misroute", 32'(ni.rx_misroute), 32'h0);
    check("rst drop count", 32'(ni.rx_drop_cnt), 32'h0);
    check("rst s_ready", 32'(ni.s_ready), 32'h0);
    rstn = 1'b1;
    step();
    check("post-rst s_ready", 32'(ni.s_ready), 32'h1);

    // Randomized traffic with occasional mid-transfer resets
    for (int c = 0; c < 3000; c++) begin
      rstn          = ($urandom_range(0, 399) != 0);
      ni.s_valid    = 1'($urandom_range(0, 1));
      ni.s_data     = 8'($urandom);
      ni.s_dest_x   = 1'($urandom_range(0, 1));
      ni.s_dest_y   = 1'($urandom_range(0, 1));
      ni.i_ready_sw = ($urandom_range(0, 3) != 0);
      ni.i_valid_sw = ($urandom_range(0, 2) != 0);
      ni.i_data_sw  = {8'($urandom), ($urandom_range(0, 15) == 0) ? 2'($urandom) : OWN_HDR};
      ni.m_ready    = ($urandom_range(0, 2) == 0);
      step();
    end
    rstn = 1'b1;
    ni.s_valid = 0; ni.i_valid_sw = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
